mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//   Shares one single-port unified memory between the instruction-fetch path and the load/store path of the MIPS core.
//   Sequences each access through a small FSM: issue, wait out the fixed memory read latency, then return data with a one-cycle ack.
//   Drives cpu_stall so the core freezes PC and pipeline state while either request is outstanding.
// PARAMETERS
//   ADDR_W       32  byte-address width of both requesters
//   DATA_W       32  data word width
//   MEM_AW       13  word-address width of the backing memory (8192 words)
//   MEM_LATENCY   1  cycles from the mem_en cycle to valid mem_rdata; legal range 1..4
// PORTS
//   clk         in   1        rising-edge clock
//   rst_n       in   1        synchronous active-low reset
//   if_req      in   1        fetch request; level, held until if_ack
//   if_addr     in   ADDR_W   fetch byte address; stable while if_req
//   if_ack      out  1        one-cycle pulse: fetch done, if_rdata valid
//   if_rdata    out  DATA_W   fetched instruction word
//   d_req       in   1        data request; level, held until d_ack
//   d_we        in   1        1 = store, 0 = load; stable while d_req
//   d_addr      in   ADDR_W   data byte address
//   d_wdata     in   DATA_W   store data
//   d_ack       out  1        one-cycle pulse: data access done, d_rdata valid on loads
//   d_rdata     out  DATA_W   load data
//   mem_en      out  1        memory access strobe, exactly one cycle per transaction
//   mem_we      out  1        memory write enable, qualified by mem_en
//   mem_addr    out  MEM_AW   word address = selected addr[MEM_AW+1:2]
//   mem_wdata   out  DATA_W   memory write data
//   mem_rdata   in   DATA_W   memory read data, valid MEM_LATENCY cycles after mem_en
//   cpu_stall   out  1        (if_req & ~if_ack) | (d_req & ~d_ack), combinational
// BEHAVIOUR
//   - Reset: state IDLE; wait counter 0; rdata regs 0. mem_en, mem_we, if_ack and d_ack are all 0. mem_addr and mem_wdata are 0. The last-served owner resets to IFETCH.
//   - Reset mid-transaction abandons the in-flight access: no ack is issued, and any late mem_rdata is ignored.
//   - FSM states are IDLE, ISSUE, WAIT, RESP. All outputs except cpu_stall are registered.
//   - IDLE: if any req is high at the clock edge, latch the winner's owner, addr, we and wdata, then go to ISSUE.
//   - ISSUE: mem_en=1 with the latched payload. A write goes to RESP. A read loads cnt=MEM_LATENCY and goes to WAIT.
//   - WAIT: decrement cnt. On the edge where cnt==1, capture mem_rdata into the owner's rdata reg, then go to RESP.
//   - RESP: pulse the owner's ack for 1 cycle, then go to IDLE. Requests are not sampled in RESP, so the requester drops req after seeing ack.
//   - Latency from req sampled to ack: write 2 cycles; read MEM_LATENCY+2 cycles.
//     Back-to-back transactions each add the IDLE cycle.
//   - Only the owner's ack and rdata change. The non-owner rdata holds its last value.
//   - Simultaneous if_req and d_req: the data requester wins, because it belongs to the older instruction in the pipe. The loser stays pending and is served next.
//   - A req dropped before its ack is a protocol error. The transaction still completes and the ack still pulses; the bench asserts on it.
//   - Address bits [1:0] and bits above MEM_AW+1 are ignored; there is no alignment check.
//   - cnt is 3 bits wide. A MEM_LATENCY outside 1..4 is an elaboration error via a generate-time check.
// CONFIGURATION
//   ARB_ROUND_ROBIN_EN defined:
//     On a tie, the requester not served last wins, and the last-served owner updates at each ISSUE.
//     This guarantees the fetch side at most one data access between its own grants.
//   ARB_ROUND_ROBIN_EN undefined:
//     Fixed priority, data over fetch. The last-served register is not built.
// STRUCTURE
//   mem_arb_pkg holds the shared constants:
//     localparam encodings for ST_IDLE/ST_ISSUE/ST_WAIT/ST_RESP (2-bit);
//     OWN_IF=0 and OWN_D=1;
//     MAX_LATENCY=4 and CNT_W=3.
//   One sub-module, arb_pick2: combinational 2-way picker.
//     Inputs: req[1:0], last_owner.
//     Output: winner.
//     Its RR behaviour is compiled in or out by ARB_ROUND_ROBIN_EN.
//   The top level holds the FSM, latency counter, payload latch, rdata regs and cpu_stall.
// TESTING
//   1. MEM_LATENCY=1, fetch read from if_addr=0x0000_0010 with memory word 4=0x2008_0005.
//      -> mem_en one cycle with mem_addr=4 and mem_we=0; if_ack 3 cycles after req; if_rdata=0x2008_0005.
//   2. Store with d_addr=0x0000_0040 and d_wdata=0xDEAD_BEEF, then load from the same address.
//      -> write: mem_we=1 with mem_addr=16, d_ack 2 cycles after req.
//      -> load: d_rdata=0xDEAD_BEEF.
//   3. if_req and d_req raised together, fixed priority.
//      -> data is served first: d_ack, then an IDLE cycle, then fetch ISSUE. if_ack arrives after d_ack. cpu_stall stays high until if_ack.
//   4. ARB_ROUND_ROBIN_EN, both reqs held for 4 transactions.
//      -> grant order D, IF, D, IF; never two consecutive grants to the same side.
//   5. MEM_LATENCY=4 read, rst_n=0 asserted in the 2nd WAIT cycle.
//      -> no ack; all outputs 0 next cycle; a new req after reset completes normally.
//   6. A requester drops req during WAIT.
//      -> ack still pulses in RESP, the protocol assertion fires, and the FSM returns to IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared constants and state type for mem_port_arbiter and its picker.
// Round-robin arbitration is selected by the ARB_ROUND_ROBIN_EN macro.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_D  = 1'b1;

  localparam int unsigned MAX_LATENCY = 4;
  localparam int unsigned CNT_W       = 3;

endpackage

// File: rtl/arb_pick2.sv
// Combinational 2-way picker between fetch and data requesters.
// ARB_ROUND_ROBIN_EN: ties go to the side not served last; otherwise data always wins.
module arb_pick2
  import mem_arb_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_owner,
  output logic       winner
);

`ifdef ARB_ROUND_ROBIN_EN
  always_comb begin
    winner = req[OWN_D] ? OWN_D : OWN_IF;
    if (req[OWN_D] && req[OWN_IF]) begin
      winner = ~last_owner;
    end
  end
`else
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    winner = req[OWN_D] ? OWN_D : OWN_IF;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and load/store.
// Build option ARB_ROUND_ROBIN_EN switches the tie-break from fixed data priority to round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_AW      = 13,
  parameter int unsigned MEM_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [MEM_AW-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              cpu_stall
);

  if (MEM_LATENCY < 1 || MEM_LATENCY > MAX_LATENCY) begin : g_bad_latency
    $error("mem_port_arbiter: MEM_LATENCY out of range 1..4");
  end

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              winner;
  logic              last_owner;

  logic              mem_en_d, mem_we_d;
  logic [MEM_AW-1:0] mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_d;
  logic              if_ack_d, d_ack_d;
  logic [DATA_W-1:0] if_rdata_d, d_rdata_d;

  // Byte offset and bits above the memory's word range play no part in addressing.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{if_addr[ADDR_W-1:MEM_AW+2], if_addr[1:0],
                              d_addr[ADDR_W-1:MEM_AW+2], d_addr[1:0]};

  arb_pick2 u_pick (
    .req        ({d_req, if_req}),
    .last_owner (last_owner),
    .winner     (winner)
  );

`ifdef ARB_ROUND_ROBIN_EN
  logic last_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      last_q <= OWN_IF;
    end else if (state_q == ST_ISSUE) begin
      last_q <= owner_q;
    end
  end

  assign last_owner = last_q;
`else
  assign last_owner = OWN_IF;
`endif

  assign cpu_stall = (if_req & ~if_ack) | (d_req & ~d_ack);

  // Every output except cpu_stall is the registered copy of its *_d value.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    owner_d     = owner_q;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr;
    mem_wdata_d = mem_wdata;
    if_ack_d    = 1'b0;
    d_ack_d     = 1'b0;
    if_rdata_d  = if_rdata;
    d_rdata_d   = d_rdata;

    case (state_q)
      ST_IDLE: begin
        if (if_req || d_req) begin
          owner_d  = winner;
          mem_en_d = 1'b1;
          if (winner == OWN_D) begin
            mem_addr_d  = d_addr[MEM_AW+1:2];
            mem_wdata_d = d_wdata;
            mem_we_d    = d_we;
          end else begin
            mem_addr_d  = if_addr[MEM_AW+1:2];
          end
          state_d = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (mem_we) begin
          if (owner_q == OWN_D) d_ack_d = 1'b1;
          else                  if_ack_d = 1'b1;
          state_d = ST_RESP;
        end else begin
          cnt_d   = CNT_W'(MEM_LATENCY);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == CNT_W'(1)) begin
          if (owner_q == OWN_D) begin
            d_rdata_d = mem_rdata;
            d_ack_d   = 1'b1;
          end else begin
            if_rdata_d = mem_rdata;
            if_ack_d   = 1'b1;
          end
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      owner_q   <= OWN_IF;
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_ack    <= 1'b0;
      d_ack     <= 1'b0;
      if_rdata  <= '0;
      d_rdata   <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      owner_q   <= owner_d;
      mem_en    <= mem_en_d;
      mem_we    <= mem_we_d;
      mem_addr  <= mem_addr_d;
      mem_wdata <= mem_wdata_d;
      if_ack    <= if_ack_d;
      d_ack     <= d_ack_d;
      if_rdata  <= if_rdata_d;
      d_rdata   <= d_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: two instances (MEM_LATENCY 1 and 4) with memory models.
// Expected tie-break follows ARB_ROUND_ROBIN_EN when the bench is built with it.
module tb_mem_port_arbiter;

`ifdef ARB_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n     [2];
  logic        if_req    [2];
  logic [31:0] if_addr   [2];
  logic        if_ack    [2];
  logic [31:0] if_rdata  [2];
  logic        d_req     [2];
  logic        d_we      [2];
  logic [31:0] d_addr    [2];
  logic [31:0] d_wdata   [2];
  logic        d_ack     [2];
  logic [31:0] d_rdata   [2];
  logic        mem_en    [2];
  logic        mem_we    [2];
  logic [12:0] mem_addr  [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
  logic        cpu_stall [2];

  int checks = 0;
  int errors = 0;

  // Reference state: sparse written words, expected rdata registers, last served side.
  logic [31:0] rmem [int];
  logic [31:0] exp_if [2];
  logic [31:0] exp_d  [2];
  logic        last   [2];

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [12:0] a);
    if (a == 13'd4) return 32'h2008_0005;
    return ({19'd0, a} * 32'h9E37_79B9) ^ 32'hA5A5_0F0F;
  endfunction

  function automatic int lat_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int unsigned LAT = (g == 0) ? 1 : 4;

    mem_port_arbiter #(.MEM_LATENCY(LAT)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n[g]),
      .if_req    (if_req[g]),
      .if_addr   (if_addr[g]),
      .if_ack    (if_ack[g]),
      .if_rdata  (if_rdata[g]),
      .d_req     (d_req[g]),
      .d_we      (d_we[g]),
      .d_addr    (d_addr[g]),
      .d_wdata   (d_wdata[g]),
      .d_ack     (d_ack[g]),
      .d_rdata   (d_rdata[g]),
      .mem_en    (mem_en[g]),
      .mem_we    (mem_we[g]),
      .mem_addr  (mem_addr[g]),
      .mem_wdata (mem_wdata[g]),
      .mem_rdata (mem_rdata[g]),
      .cpu_stall (cpu_stall[g])
    );

    logic [31:0] mem [8192];
    logic [3:0]  pv = '0;
    logic [31:0] pd [4];

    initial begin
      for (int i = 0; i < 8192; i++) mem[i] = init_word(13'(i));
    end

    // Read data is valid exactly LAT cycles after the mem_en cycle, garbage otherwise.
    always @(posedge clk) begin
      pv    <= {pv[2:0], mem_en[g] & ~mem_we[g]};
      pd[0] <= mem[mem_addr[g]];
      for (int i = 1; i < 4; i++) pd[i] <= pd[i-1];
      if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
    end

    assign mem_rdata[g] = pv[LAT-1] ? pd[LAT-1] : 32'hBADC_0FFE;

    // Protocol monitor: a request dropped before its ack was seen.
    int   viol_d = 0, viol_i = 0;
    logic dq = 1'b0, iq = 1'b0, da = 1'b0, ia = 1'b0;

    always @(negedge clk) begin
      if (d_req[g] && !dq) da <= d_ack[g];
      else if (d_ack[g])   da <= 1'b1;
      if (if_req[g] && !iq) ia <= if_ack[g];
      else if (if_ack[g])   ia <= 1'b1;
      if (dq && !d_req[g] && !da && !d_ack[g])   viol_d <= viol_d + 1;
      if (iq && !if_req[g] && !ia && !if_ack[g]) viol_i <= viol_i + 1;
      dq <= d_req[g];
      iq <= if_req[g];
    end
  end

  function automatic int get_viol(input int k);
    return (k == 0) ? g_dut[0].viol_d + g_dut[0].viol_i
                    : g_dut[1].viol_d + g_dut[1].viol_i;
  endfunction

  function automatic logic [31:0] ref_rd(input int k, input logic [12:0] a);
    int key = k * 8192 + int'(a);
    return rmem.exists(key) ? rmem[key] : init_word(a);
  endfunction

  task automatic ref_wr(input int k, input logic [12:0] a, input logic [31:0] v);
    rmem[k * 8192 + int'(a)] = v;
  endtask

  function automatic logic [31:0] rnd_addr();
    logic [31:0] a;
    a = $urandom();
    a[14:2] = 13'($urandom_range(0, 31));
    return a;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_zero_outputs(input int k, input string tag);
    chk({tag, "_if_ack"},    32'(if_ack[k]),    '0);
    chk({tag, "_d_ack"},     32'(d_ack[k]),     '0);
    chk({tag, "_mem_en"},    32'(mem_en[k]),    '0);
    chk({tag, "_mem_we"},    32'(mem_we[k]),    '0);
    chk({tag, "_mem_addr"},  32'(mem_addr[k]),  '0);
    chk({tag, "_mem_wdata"}, mem_wdata[k],      '0);
    chk({tag, "_if_rdata"},  if_rdata[k],       '0);
    chk({tag, "_d_rdata"},   d_rdata[k],        '0);
  endtask

  // One isolated transaction; returns with the DUT back in IDLE.
  task automatic txn(input int k, input bit is_d, input bit we, input logic [31:0] addr,
                     input logic [31:0] wd);
    int n = 0, en_cnt = 0, stall_bad = 0;
    bit got = 1'b0;
    bit xwe = is_d & we;
    logic [12:0] s_addr = '0;
    logic        s_we = 1'b0;
    logic [31:0] s_wd = '0;
    if (is_d) begin
      d_we[k] = we; d_addr[k] = addr; d_wdata[k] = wd; d_req[k] = 1'b1;
    end else begin
      if_addr[k] = addr; if_req[k] = 1'b1;
    end
    while (!got && n < 30) begin
      @(posedge clk); #1; n++;
      if (mem_en[k]) begin
        en_cnt++; s_addr = mem_addr[k]; s_we = mem_we[k]; s_wd = mem_wdata[k];
      end
      if (if_ack[k] || d_ack[k]) got = 1'b1;
      else if (cpu_stall[k] !== 1'b1) stall_bad++;
    end
    chk("txn_ack_seen", 32'(got), 32'd1);
    if (got) begin
      chk("txn_ack_side", {30'd0, if_ack[k], d_ack[k]}, {30'd0, ~is_d, is_d});
      chk("txn_latency", n, xwe ? 2 : lat_of(k) + 2);
      chk("txn_mem_en_count", en_cnt, 1);
      chk("txn_mem_addr", 32'(s_addr), 32'(addr[14:2]));
      chk("txn_mem_we", 32'(s_we), 32'(xwe));
      if (xwe) begin
        chk("txn_mem_wdata", s_wd, wd);
        ref_wr(k, addr[14:2], wd);
      end else if (is_d) begin
        exp_d[k] = ref_rd(k, addr[14:2]);
      end else begin
        exp_if[k] = ref_rd(k, addr[14:2]);
      end
      chk("txn_if_rdata", if_rdata[k], exp_if[k]);
      chk("txn_d_rdata", d_rdata[k], exp_d[k]);
      chk("txn_stall_on_ack", 32'(cpu_stall[k]), '0);
      chk("txn_stall_while_pending", stall_bad, 0);
      last[k] = is_d;
    end
    if_req[k] = 1'b0; d_req[k] = 1'b0;
    @(posedge clk); #1;
    chk("txn_ack_one_cycle", {30'd0, if_ack[k], d_ack[k]}, '0);
  endtask

  // Both sides hold requests for nd data and ni fetch transactions.
  task automatic both(input int k, input int nd, input int ni);
    int rd = nd, ri = ni, n = 0, budget, stall_bad = 0;
    bit first = 1'b1, win, xwe;
    logic        dwe;
    logic [31:0] dad, dwd, iad;
    dwe = 1'($urandom_range(0, 1)); dad = rnd_addr(); dwd = $urandom(); iad = rnd_addr();
    d_we[k] = dwe; d_addr[k] = dad; d_wdata[k] = dwd; if_addr[k] = iad;
    d_req[k] = (rd > 0); if_req[k] = (ri > 0);
    budget = (nd + ni) * 12 + 10;
    while ((rd > 0 || ri > 0) && budget > 0) begin
      @(posedge clk); #1; n++; budget--;
      if (if_ack[k] || d_ack[k]) begin
        if (rd > 0 && ri > 0) win = RR ? ~last[k] : 1'b1;
        else                  win = (rd > 0);
        xwe = win & dwe;
        chk("both_ack_side", {30'd0, if_ack[k], d_ack[k]}, {30'd0, ~win, win});
        chk("both_gap", n, (first ? 0 : 1) + (xwe ? 2 : lat_of(k) + 2));
        chk("both_stall_on_ack", 32'(cpu_stall[k]), 32'(win ? (ri > 0) : (rd > 0)));
        last[k] = win;
        if (win) begin
          if (dwe) ref_wr(k, dad[14:2], dwd);
          else     exp_d[k] = ref_rd(k, dad[14:2]);
          chk("both_d_rdata", d_rdata[k], exp_d[k]);
          chk("both_if_rdata_hold", if_rdata[k], exp_if[k]);
          rd--;
          if (rd > 0) begin
            dwe = 1'($urandom_range(0, 1)); dad = rnd_addr(); dwd = $urandom();
            d_we[k] = dwe; d_addr[k] = dad; d_wdata[k] = dwd;
          end else d_req[k] = 1'b0;
        end else begin
          exp_if[k] = ref_rd(k, iad[14:2]);
          chk("both_if_rdata", if_rdata[k], exp_if[k]);
          chk("both_d_rdata_hold", d_rdata[k], exp_d[k]);
          ri--;
          if (ri > 0) begin
            iad = rnd_addr(); if_addr[k] = iad;
          end else if_req[k] = 1'b0;
        end
        first = 1'b0; n = 0;
      end else if (cpu_stall[k] !== 1'b1) stall_bad++;
    end
    chk("both_all_served", rd + ri, 0);
    chk("both_stall_while_pending", stall_bad, 0);
    if_req[k] = 1'b0; d_req[k] = 1'b0;
    @(posedge clk); #1;
    chk("both_ack_one_cycle", {30'd0, if_ack[k], d_ack[k]}, '0);
  endtask

  initial begin
    int n;
    bit got;
    for (int k = 0; k < 2; k++) begin
      rst_n[k] = 1'b0; if_req[k] = 1'b0; if_addr[k] = '0; d_req[k] = 1'b0;
      d_we[k] = 1'b0; d_addr[k] = '0; d_wdata[k] = '0;
      exp_if[k] = '0; exp_d[k] = '0; last[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      chk_zero_outputs(k, "reset");
      chk("reset_stall", 32'(cpu_stall[k]), '0);
      rst_n[k] = 1'b1;
    end
    @(posedge clk); #1;

    // Fetch of word 4, then store/load round trip, on both latencies.
    for (int k = 0; k < 2; k++) begin
      txn(k, 1'b0, 1'b0, 32'h0000_0010, '0);
      chk("fetch_word4", if_rdata[k], 32'h2008_0005);
      txn(k, 1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF);
      txn(k, 1'b1, 1'b0, 32'h0000_0040, '0);
      chk("load_back", d_rdata[k], 32'hDEAD_BEEF);
    end

    // Simultaneous requests, then both held for four grants.
    for (int k = 0; k < 2; k++) begin
      both(k, 1, 1);
      both(k, 2, 2);
    end

    // Reset in the second WAIT cycle of a latency-4 read.
    if_addr[1] = 32'h0000_0010; if_req[1] = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_issue", 32'(mem_en[1]), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    rst_n[1] = 1'b0; if_req[1] = 1'b0;
    @(posedge clk); #1;
    chk_zero_outputs(1, "rst_mid");
    exp_if[1] = '0; exp_d[1] = '0; last[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (if_ack[1] || d_ack[1]) n++;
    end
    chk("rst_mid_no_ack", n, 0);
    chk("rst_mid_rdata_clear", if_rdata[1], '0);
    txn(1, 1'b0, 1'b0, 32'h0000_0010, '0);
    chk("rst_mid_recover", if_rdata[1], 32'h2008_0005);

    // Data requester drops req during WAIT: ack still pulses, monitor flags it.
    chk("proto_before", get_viol(0), 0);
    d_we[0] = 1'b0; d_addr[0] = 32'h0000_0040; d_req[0] = 1'b1;
    n = 0; got = 1'b0;
    while (!got && n < 10) begin
      @(posedge clk); #1; n++;
      if (n == 2) d_req[0] = 1'b0;
      if (d_ack[0]) got = 1'b1;
    end
    chk("drop_ack_seen", 32'(got), 32'd1);
    chk("drop_ack_latency", n, 3);
    exp_d[0] = ref_rd(0, 13'd16);
    chk("drop_d_rdata", d_rdata[0], exp_d[0]);
    last[0] = 1'b1;
    @(posedge clk); #1;
    chk("drop_ack_one_cycle", 32'(d_ack[0]), '0);
    chk("proto_fired", get_viol(0), 1);
    txn(0, 1'b0, 1'b0, 32'h0000_0010, '0);

    // Randomized isolated and contended traffic.
    for (int i = 0; i < 30; i++) begin
      int  k = $urandom_range(0, 1);
      bit  is_d = 1'($urandom_range(0, 1));
      bit  we = is_d & 1'($urandom_range(0, 1));
      txn(k, is_d, we, rnd_addr(), $urandom());
    end
    for (int i = 0; i < 6; i++) begin
      both($urandom_range(0, 1), $urandom_range(1, 3), $urandom_range(1, 3));
    end
    chk("proto_total", get_viol(0), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
